// File: rtl/gcd_stream_driver.sv
// gcd_stream_driver: valid/ready stream adapter in front of a four-phase GCD core.
// Sequences operand a, operand b and result collection over gcd_req/gcd_ack.
//
// Parameters:
//   W   operand/result width (must match the attached core)
//   CW  width of the saturating cycle counter
//
// Ports:
//   clock, reset_n                  clock and async active-low reset
//   in_valid/in_ready/in_a/in_b     operand pair input stream
//   out_valid/out_ready             result output stream
//   out_result/out_cycles           gcd(a,b) and accept-to-capture edge count
//   gcd_req/gcd_ack                 four-phase handshake with the core
//   gcd_load_val/gcd_result         operand to core, result from core
//
// Optional feature macro: GCD_STREAM_DRIVER_ZERO_BYPASS_EN
//   When defined, pairs with a zero operand skip the core and return a|b.
module gcd_stream_driver #(
    parameter int W  = 128,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_result,
    output logic [CW-1:0] out_cycles,
    output logic          gcd_req,
    input  logic          gcd_ack,
    output logic [W-1:0]  gcd_load_val,
    input  logic [W-1:0]  gcd_result
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        REL_A,
        REQ_B,
        REL_B,
        OUT
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_q;
    logic [W-1:0]  a_d;
    logic [W-1:0]  b_q;
    logic [W-1:0]  b_d;
    logic [W-1:0]  res_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] cyc_d;

    // Saturating increment: the count sticks at all-ones.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = out_result;
        cyc_d   = out_cycles;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    cnt_d = '0;
`ifdef GCD_STREAM_DRIVER_ZERO_BYPASS_EN
                    if (in_a == '0 || in_b == '0) begin
                        state_d = OUT;
                        res_d   = in_a | in_b;
                        cyc_d   = '0;
                    end else begin
                        state_d = REQ_A;
                    end
`else
                    state_d = REQ_A;
`endif
                end
            end
            REQ_A: begin
                cnt_d = cnt_inc;
                if (gcd_ack) begin
                    state_d = REL_A;
                end
            end
            REL_A: begin
                cnt_d = cnt_inc;
                if (!gcd_ack) begin
                    state_d = REQ_B;
                end
            end
            REQ_B: begin
                cnt_d = cnt_inc;
                if (gcd_ack) begin
                    res_d   = gcd_result;
                    // The capture edge itself is part of the count.
                    cyc_d   = cnt_inc;
                    state_d = REL_B;
                end
            end
            REL_B: begin
                if (!gcd_ack) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they change
    // on the same edge as the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            gcd_req      <= 1'b0;
            gcd_load_val <= '0;
            out_result   <= '0;
            out_cycles   <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            in_ready     <= (state_d == IDLE);
            out_valid    <= (state_d == OUT);
            gcd_req      <= (state_d == REQ_A) || (state_d == REQ_B);
            // The core samples the load value while waiting, so it must
            // already hold the right operand whenever req is high.
            gcd_load_val <= ((state_d == IDLE) || (state_d == REQ_A)) ? a_d : b_d;
            out_result   <= res_d;
            out_cycles   <= cyc_d;
        end
    end

endmodule

// File: tb/tb_gcd_stream_driver.sv
// tb_gcd_stream_driver: directed bench for gcd_stream_driver with a
// registered-ack subtraction GCD core model (2 cycles per step).
module tb_gcd_stream_driver;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_result;
    logic [15:0]  out_cycles;
    logic         gcd_req;
    logic         gcd_ack;
    logic [127:0] gcd_load_val;
    logic [127:0] gcd_result;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [7:0]   s_in_a;
    logic [7:0]   s_in_b;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [7:0]   s_out_result;
    logic [3:0]   s_out_cycles;
    logic         s_req;
    logic         s_ack;
    logic [7:0]   s_load;
    logic [7:0]   s_res;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gcd_stream_driver #(.W(128), .CW(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cycles(out_cycles),
        .gcd_req(gcd_req), .gcd_ack(gcd_ack),
        .gcd_load_val(gcd_load_val), .gcd_result(gcd_result)
    );

    gcd_stream_driver #(.W(8), .CW(4)) dut_sat (
        .clock(clock), .reset_n(reset_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_result(s_out_result), .out_cycles(s_out_cycles),
        .gcd_req(s_req), .gcd_ack(s_ack),
        .gcd_load_val(s_load), .gcd_result(s_res)
    );

    typedef enum logic [2:0] {C_IDLE, C_AACK, C_WAITB, C_CALC, C_RES} cst_t;

    cst_t         cst;
    logic [127:0] cx;
    logic [127:0] cy;
    logic         cph;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cst <= C_IDLE; cx <= '0; cy <= '0; cph <= 1'b0;
            gcd_ack <= 1'b0; gcd_result <= '0;
        end else begin
            case (cst)
                C_IDLE: begin
                    cx <= gcd_load_val;
                    if (gcd_req) begin gcd_ack <= 1'b1; cst <= C_AACK; end
                end
                C_AACK: if (!gcd_req) begin gcd_ack <= 1'b0; cst <= C_WAITB; end
                C_WAITB: begin
                    cy <= gcd_load_val;
                    if (gcd_req) begin cph <= 1'b0; cst <= C_CALC; end
                end
                C_CALC: begin
                    if (cx == cy) begin
                        gcd_result <= cx; gcd_ack <= 1'b1; cst <= C_RES;
                    end else if (!cph) begin
                        cph <= 1'b1;
                    end else begin
                        cph <= 1'b0;
                        if (cx > cy) cx <= cx - cy;
                        else cy <= cy - cx;
                    end
                end
                C_RES: if (!gcd_req) begin gcd_ack <= 1'b0; cst <= C_IDLE; end
                default: cst <= C_IDLE;
            endcase
        end
    end

    cst_t       sst;
    logic [7:0] sx;
    logic [7:0] sy;
    logic       sph;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sst <= C_IDLE; sx <= '0; sy <= '0; sph <= 1'b0;
            s_ack <= 1'b0; s_res <= '0;
        end else begin
            case (sst)
                C_IDLE: begin
                    sx <= s_load;
                    if (s_req) begin s_ack <= 1'b1; sst <= C_AACK; end
                end
                C_AACK: if (!s_req) begin s_ack <= 1'b0; sst <= C_WAITB; end
                C_WAITB: begin
                    sy <= s_load;
                    if (s_req) begin sph <= 1'b0; sst <= C_CALC; end
                end
                C_CALC: begin
                    if (sx == sy) begin
                        s_res <= sx; s_ack <= 1'b1; sst <= C_RES;
                    end else if (!sph) begin
                        sph <= 1'b1;
                    end else begin
                        sph <= 1'b0;
                        if (sx > sy) sx <= sx - sy;
                        else sy <= sy - sx;
                    end
                end
                C_RES: if (!s_req) begin s_ack <= 1'b0; sst <= C_IDLE; end
                default: sst <= C_IDLE;
            endcase
        end
    end

    task automatic send(input logic [127:0] a, input logic [127:0] b);
        int n;
        @(negedge clock);
        in_a = a; in_b = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int pulses, output bit ok);
        logic prev;
        int n;
        prev = 1'b0; pulses = 0; ok = 1'b0; n = 0;
        while (!ok && n < 2000) begin
            @(negedge clock);
            if (gcd_req && !prev) pulses++;
            prev = gcd_req;
            if (out_valid) ok = 1'b1;
            n++;
        end
    endtask

    task automatic take();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_out_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (gcd_req !== 1'b0) begin errors++; $display("FAIL rst_gcd_req got %b want 0", gcd_req); end
        checks++; if (gcd_load_val !== 128'd0) begin errors++; $display("FAIL rst_load_val got %0d want 0", gcd_load_val); end
        checks++; if (out_result !== 128'd0) begin errors++; $display("FAIL rst_out_result got %0d want 0", out_result); end
        checks++; if (out_cycles !== 16'd0) begin errors++; $display("FAIL rst_out_cycles got %0d want 0", out_cycles); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_sat_in_ready got %b want 1", s_in_ready); end
    endtask

    task automatic test_equal();
        int p; bit ok;
        send(128'd7, 128'd7);
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL eq_timeout got 0 want 1"); end
        checks++; if (out_result !== 128'd7) begin errors++; $display("FAIL eq_result got %0d want 7", out_result); end
        checks++; if (out_cycles !== 16'd7) begin errors++; $display("FAIL eq_cycles got %0d want 7", out_cycles); end
        checks++; if (p != 2) begin errors++; $display("FAIL eq_req_pulses got %0d want 2", p); end
        take();
    endtask

    task automatic test_hold();
        int p; bit ok; int bad;
        send(128'd48, 128'd18);
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got 0 want 1"); end
        checks++; if (out_result !== 128'd6) begin errors++; $display("FAIL hold_result got %0d want 6", out_result); end
        checks++; if (out_cycles !== 16'd15) begin errors++; $display("FAIL hold_cycles got %0d want 15", out_cycles); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (out_valid !== 1'b1 || out_result !== 128'd6 || out_cycles !== 16'd15) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        take();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drop got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int p; bit ok; int n; int hi;
        @(negedge clock);
        in_a = 128'd12; in_b = 128'd8; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_a = 128'd35; in_b = 128'd14;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", in_ready); end
        n = 0; hi = 0;
        while (!out_valid && n < 2000) begin
            @(negedge clock);
            if (in_ready) hi++;
            n++;
        end
        checks++; if (!out_valid) begin errors++; $display("FAIL b2b_timeout1 got 0 want 1"); end
        checks++; if (hi != 0) begin errors++; $display("FAIL b2b_ready_low got %0d high cycles want 0", hi); end
        checks++; if (out_result !== 128'd4) begin errors++; $display("FAIL b2b_result1 got %0d want 4", out_result); end
        checks++; if (out_cycles !== 16'd11) begin errors++; $display("FAIL b2b_cycles1 got %0d want 11", out_cycles); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_out got %b want 0", in_ready); end
        take();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got %b want 1", in_ready); end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2 got %b want 0", in_ready); end
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout2 got 0 want 1"); end
        checks++; if (out_result !== 128'd7) begin errors++; $display("FAIL b2b_result2 got %0d want 7", out_result); end
        checks++; if (out_cycles !== 16'd13) begin errors++; $display("FAIL b2b_cycles2 got %0d want 13", out_cycles); end
        take();
    endtask

    task automatic test_reset_mid();
        int p; bit ok; int n; logic prev;
        send(128'd48, 128'd18);
        prev = 1'b0; p = 0; n = 0;
        while (p < 2 && n < 200) begin
            @(negedge clock);
            if (gcd_req && !prev) p++;
            prev = gcd_req;
            n++;
        end
        checks++; if (p != 2) begin errors++; $display("FAIL mid_reach_reqb got %0d pulses want 2", p); end
        reset_n = 1'b0;
        #1;
        checks++; if (gcd_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", gcd_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        @(negedge clock);
        reset_n = 1'b1;
        send(128'd9, 128'd6);
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got 0 want 1"); end
        checks++; if (out_result !== 128'd3) begin errors++; $display("FAIL mid_result got %0d want 3", out_result); end
        checks++; if (out_cycles !== 16'd11) begin errors++; $display("FAIL mid_cycles got %0d want 11", out_cycles); end
        take();
    endtask

`ifdef GCD_STREAM_DRIVER_ZERO_BYPASS_EN
    task automatic test_bypass();
        int p; bit ok;
        send(128'd0, 128'd5);
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL byp5_timeout got 0 want 1"); end
        checks++; if (out_result !== 128'd5) begin errors++; $display("FAIL byp5_result got %0d want 5", out_result); end
        checks++; if (out_cycles !== 16'd0) begin errors++; $display("FAIL byp5_cycles got %0d want 0", out_cycles); end
        checks++; if (p != 0) begin errors++; $display("FAIL byp5_req got %0d pulses want 0", p); end
        take();
        send(128'd0, 128'd0);
        wait_out(p, ok);
        checks++; if (!ok) begin errors++; $display("FAIL byp0_timeout got 0 want 1"); end
        checks++; if (out_result !== 128'd0) begin errors++; $display("FAIL byp0_result got %0d want 0", out_result); end
        checks++; if (out_cycles !== 16'd0) begin errors++; $display("FAIL byp0_cycles got %0d want 0", out_cycles); end
        checks++; if (p != 0) begin errors++; $display("FAIL byp0_req got %0d pulses want 0", p); end
        take();
    endtask
`endif

    task automatic test_saturate();
        int n;
        @(negedge clock);
        s_in_a = 8'hFF; s_in_b = 8'h01; s_in_valid = 1'b1;
        @(posedge clock);
        #1;
        s_in_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++; if (!s_out_valid) begin errors++; $display("FAIL sat_timeout got 0 want 1"); end
        checks++; if (s_out_result !== 8'd1) begin errors++; $display("FAIL sat_result got %0d want 1", s_out_result); end
        checks++; if (s_out_cycles !== 4'd15) begin errors++; $display("FAIL sat_cycles got %0d want 15", s_out_cycles); end
        @(negedge clock);
        s_out_ready = 1'b1;
        @(posedge clock);
        #1;
        s_out_ready = 1'b0;
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL sat_idle got %b want 1", s_in_ready); end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef GCD_STREAM_DRIVER_ZERO_BYPASS_EN
        test_bypass();
`endif
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcd_stream_driver.md
# gcd_stream_driver

Stream-to-handshake adapter placed directly upstream of the GCD core. It accepts operand pairs on a valid/ready stream and drives the core's four-phase `req`/`ack` protocol: operand a, then operand b, then result collection. Each result is returned on a valid/ready output stream with a per-operation cycle count. The block owns the sequencing, so producers never see the core's serial load protocol.

## Interface
- `W`, 128: operand/result width; must match the attached GCD core.
- `CW`, 16: width of the cycle-count output.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  driver can accept a pair.
- `in_a`  in  W  operand a.
- `in_b`  in  W  operand b.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  W  gcd(a, b).
- `out_cycles`  out  CW  clock edges from accept to result capture, saturating.
- `gcd_req`  out  1  request to core.
- `gcd_ack`  in  1  acknowledge from core.
- `gcd_load_val`  out  W  operand presented to core.
- `gcd_result`  in  W  core result, valid while `gcd_ack` is high in the result phase.

## Operation
- The FSM has six states: IDLE, REQ_A, REL_A, REQ_B, REL_B, OUT. Reset state is IDLE.
- **IDLE:** `in_ready`=1. On `in_valid`, latch `in_a`/`in_b` into `a_q`/`b_q`, clear the cycle counter, and go to REQ_A.
- **REQ_A:** `gcd_req`=1. Move to REL_A when sampled `gcd_ack`=1.
- **REL_A:** `gcd_req`=0. Move to REQ_B when sampled `gcd_ack`=0.
- **REQ_B:** `gcd_req`=1. When sampled `gcd_ack`=1, capture `gcd_result` into `out_result` and the counter into `out_cycles`, then go to REL_B.
- **REL_B:** `gcd_req`=0. Move to OUT when sampled `gcd_ack`=0.
- **OUT:** `out_valid`=1 and outputs are held stable. On `out_ready`, go to IDLE.
- `gcd_load_val` = `a_q` in IDLE and REQ_A; `b_q` in all other states. The core latches its load value continuously while waiting, so this value must be valid whenever `gcd_req` is high.
- Cycle counter: increments on every edge from REQ_A through the capture edge. It saturates at 2^CW-1 and does not wrap.
- `in_valid` outside IDLE is ignored; no pair is accepted or dropped.
- An `out_ready` that arrives before OUT has no effect.

## Timing
- All outputs are registered. Reset values: `in_ready`=1, and `out_valid`, `gcd_req`, `gcd_load_val`, `out_result` and `out_cycles` are all 0.
- Reset asserted at any point, including mid-handshake, returns the FSM to IDLE immediately with `gcd_req`=0. The core shares the same reset, so both resynchronise.
- With a registered-`ack` core, `out_cycles` = 7 + 2·(number of subtraction steps).
- `out_valid` rises 2 edges after capture: REL_B plus the core dropping `ack`.
- Throughput: one pair per operation. `in_ready` is high only in IDLE, which lasts at least one cycle after each OUT handshake.

## Configuration
- Macro: `GCD_STREAM_DRIVER_ZERO_BYPASS_EN`.
- **Defined:** a pair with `in_a`==0 or `in_b`==0 never reaches the core. IDLE goes directly to OUT with `out_result` = `in_a | in_b` (gcd(x,0)=x, gcd(0,0)=0), `out_cycles`=0 and `gcd_req` held at 0.
- **Undefined:** zero operands are forwarded unchanged. The core does not terminate for exactly one zero operand, so producers must not send one.

## Test plan
- a=7, b=7 -> `out_result`=7 and `out_cycles`=7; `gcd_req` shows exactly two high pulses.
- a=48, b=18 -> `out_result`=6 and `out_cycles`=15; with `out_ready` held low for 10 cycles, result, count and `out_valid` stay stable.
- Back-to-back pairs (12,8) then (35,14) with `in_valid` held high -> results 4 then 7, in order. `in_ready` is low from the first accept until the first OUT handshake completes.
- Reset pulsed low while in REQ_B -> `gcd_req`=0 and `out_valid`=0 immediately. A following pair (9,6) returns 3.
- With the macro defined: (0,5) returns 5 and (0,0) returns 0, each with `out_cycles`=0 and `gcd_req` never asserted.
- Drive `in_a`=2^W-1 and `in_b`=1 with CW=4 -> `out_result`=1 and `out_cycles` saturates at 15 without wrapping (long run; use W=8).
